// File: rtl/idex_hazard_if.sv
// ID/EX stage bundle: ID-side decoded fields in, EX-side registered fields and IF/ID stall out.
// Directions are named from the stage's point of view (_i into the stage, _o out of it).
interface idex_hazard_if #(
    parameter int DW = 32
);
    logic          hold_i;
    logic          flush_i;
    logic [4:0]    id_rs_i;
    logic [4:0]    id_rt_i;
    logic [4:0]    id_wba_i;
    logic [2:0]    id_instr_type_i;
    logic [DW-1:0] id_a_i;
    logic [DW-1:0] id_b_i;
    logic [DW-1:0] id_imm_i;

    logic [4:0]    idex_rs_o;
    logic [4:0]    idex_rt_o;
    logic [4:0]    idex_wba_o;
    logic [2:0]    idex_instr_type_o;
    logic [DW-1:0] idex_a_o;
    logic [DW-1:0] idex_b_o;
    logic [DW-1:0] idex_imm_o;
    logic          stall_ifid_o;

    modport slave (
        input  hold_i, flush_i, id_rs_i, id_rt_i, id_wba_i, id_instr_type_i,
               id_a_i, id_b_i, id_imm_i,
        output idex_rs_o, idex_rt_o, idex_wba_o, idex_instr_type_o,
               idex_a_o, idex_b_o, idex_imm_o, stall_ifid_o
    );

    modport master (
        output hold_i, flush_i, id_rs_i, id_rt_i, id_wba_i, id_instr_type_i,
               id_a_i, id_b_i, id_imm_i,
        input  idex_rs_o, idex_rt_o, idex_wba_o, idex_instr_type_o,
               idex_a_o, idex_b_o, idex_imm_o, stall_ifid_o
    );
endinterface

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and global hold.
//   state | meaning
//   RUN   | normal flow; a load-use hazard inserts the first bubble here
//   STALL | further bubbles while cnt_q counts down, IF/ID held
module idex_hazard_stage #(
    parameter int DW         = 32,
    parameter int LOAD_STALL = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    idex_hazard_if.slave    bus
);
    typedef enum logic {RUN, STALL} state_t;

    localparam logic [2:0] TYPE_NOP   = 3'd5;
    localparam logic [2:0] TYPE_LOAD  = 3'd2;
    localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL - 1);

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [4:0]    rs_q, rs_d, rt_q, rt_d, wba_q, wba_d;
    logic [2:0]    type_q, type_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic          uses_rt, hazard, stall;

    always_comb begin
        uses_rt = (bus.id_instr_type_i == 3'd0) || (bus.id_instr_type_i == 3'd3);
        hazard  = (type_q == TYPE_LOAD) && (wba_q != 5'd0) &&
                  ((bus.id_rs_i == wba_q) || (uses_rt && (bus.id_rt_i == wba_q)));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        wba_d   = wba_q;
        type_d  = type_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        stall   = 1'b0;

        if (bus.hold_i) begin
            stall = 1'b1;
        end else begin
            // bubble by default; only the normal-load branch overrides it
            rs_d   = 5'd0;
            rt_d   = 5'd0;
            wba_d  = 5'd0;
            type_d = TYPE_NOP;
            a_d    = '0;
            b_d    = '0;
            imm_d  = '0;
            if (bus.flush_i) begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end else if (state_q == STALL) begin
                stall = 1'b1;
                if (cnt_q <= 3'd1) begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end else if (hazard) begin
                stall   = 1'b1;
                cnt_d   = STALL_INIT;
                state_d = (LOAD_STALL > 1) ? STALL : RUN;
            end else begin
                rs_d   = bus.id_rs_i;
                rt_d   = bus.id_rt_i;
                wba_d  = bus.id_wba_i;
                type_d = bus.id_instr_type_i;
                a_d    = bus.id_a_i;
                b_d    = bus.id_b_i;
                imm_d  = bus.id_imm_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
            rs_q    <= 5'd0;
            rt_q    <= 5'd0;
            wba_q   <= 5'd0;
            type_q  <= TYPE_NOP;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            wba_q   <= wba_d;
            type_q  <= type_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
        end
    end

    assign bus.idex_rs_o         = rs_q;
    assign bus.idex_rt_o         = rt_q;
    assign bus.idex_wba_o        = wba_q;
    assign bus.idex_instr_type_o = type_q;
    assign bus.idex_a_o          = a_q;
    assign bus.idex_b_o          = b_q;
    assign bus.idex_imm_o        = imm_q;
    assign bus.stall_ifid_o      = stall;
endmodule

// File: tb/tb_idex_hazard_stage.sv
// Drives two stages (LOAD_STALL=1 and 3) with identical stimulus and checks each
// against a bubble-count reference model, plus directed literal expectations.
module tb_idex_hazard_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    idex_hazard_if #(.DW(32)) if_a ();
    idex_hazard_if #(.DW(32)) if_b ();

    idex_hazard_stage #(.DW(32), .LOAD_STALL(1)) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(if_a));
    idex_hazard_stage #(.DW(32), .LOAD_STALL(3)) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(if_b));

    typedef struct packed {
        logic        rst_n;
        logic        hold;
        logic        flush;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wba;
        logic [2:0]  ty;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } stim_t;

    // EX contents plus number of bubbles still owed after the current one
    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wba;
        logic [2:0]  ty;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        int          rem;
    } mdl_t;

    int    checks   = 0;
    int    failures = 0;
    bit    armed    = 1'b0;
    stim_t cur;
    mdl_t  ma, mb;

    function automatic mdl_t bubble(int rem);
        mdl_t n = '0;
        n.ty  = 3'd5;
        n.rem = rem;
        return n;
    endfunction

    function automatic bit haz(mdl_t m, stim_t s);
        bit reads_rt = (s.ty == 3'd0) || (s.ty == 3'd3);
        return (m.ty == 3'd2) && (m.wba != 0) && ((s.rs == m.wba) || (reads_rt && s.rt == m.wba));
    endfunction

    function automatic bit exp_stall(mdl_t m, stim_t s);
        if (s.hold) return 1'b1;
        if (s.flush) return 1'b0;
        return (m.rem > 0) || haz(m, s);
    endfunction

    function automatic mdl_t step(mdl_t m, int ls, stim_t s);
        mdl_t n;
        if (!s.rst_n)               n = bubble(0);
        else if (s.hold)            n = m;
        else if (s.flush)           n = bubble(0);
        else if (m.rem > 0)         n = bubble(m.rem - 1);
        else if (haz(m, s))         n = bubble(ls - 1);
        else begin
            n     = '0;
            n.rs  = s.rs;  n.rt = s.rt;  n.wba = s.wba;  n.ty = s.ty;
            n.a   = s.a;   n.b  = s.b;   n.imm = s.imm;
        end
        return n;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic drive(stim_t s);
        cur   = s;
        rst_n = s.rst_n;
        if_a.hold_i = s.hold;   if_b.hold_i = s.hold;
        if_a.flush_i = s.flush; if_b.flush_i = s.flush;
        if_a.id_rs_i = s.rs;    if_b.id_rs_i = s.rs;
        if_a.id_rt_i = s.rt;    if_b.id_rt_i = s.rt;
        if_a.id_wba_i = s.wba;  if_b.id_wba_i = s.wba;
        if_a.id_instr_type_i = s.ty; if_b.id_instr_type_i = s.ty;
        if_a.id_a_i = s.a;      if_b.id_a_i = s.a;
        if_a.id_b_i = s.b;      if_b.id_b_i = s.b;
        if_a.id_imm_i = s.imm;  if_b.id_imm_i = s.imm;
    endtask

    task automatic compare_all();
        chk("a_rs",    32'(if_a.idex_rs_o),         32'(ma.rs));
        chk("a_rt",    32'(if_a.idex_rt_o),         32'(ma.rt));
        chk("a_wba",   32'(if_a.idex_wba_o),        32'(ma.wba));
        chk("a_type",  32'(if_a.idex_instr_type_o), 32'(ma.ty));
        chk("a_opa",   if_a.idex_a_o,               ma.a);
        chk("a_opb",   if_a.idex_b_o,               ma.b);
        chk("a_imm",   if_a.idex_imm_o,             ma.imm);
        chk("a_stall", 32'(if_a.stall_ifid_o),      32'(exp_stall(ma, cur)));
        chk("b_rs",    32'(if_b.idex_rs_o),         32'(mb.rs));
        chk("b_rt",    32'(if_b.idex_rt_o),         32'(mb.rt));
        chk("b_wba",   32'(if_b.idex_wba_o),        32'(mb.wba));
        chk("b_type",  32'(if_b.idex_instr_type_o), 32'(mb.ty));
        chk("b_opa",   if_b.idex_a_o,               mb.a);
        chk("b_opb",   if_b.idex_b_o,               mb.b);
        chk("b_imm",   if_b.idex_imm_o,             mb.imm);
        chk("b_stall", 32'(if_b.stall_ifid_o),      32'(exp_stall(mb, cur)));
    endtask

    // compare at negedge, then advance DUT and model together on the posedge
    task automatic tick();
        @(negedge clk);
        if (armed) compare_all();
        @(posedge clk);
        ma = step(ma, 1, cur);
        mb = step(mb, 3, cur);
        if (!cur.rst_n) armed = 1'b1;
        #1;
    endtask

    function automatic stim_t mk(logic [2:0] ty, logic [4:0] rs, logic [4:0] rt, logic [4:0] wba,
                                 logic [31:0] a, logic [31:0] b);
        stim_t s = '0;
        s.rst_n = 1'b1;
        s.ty = ty; s.rs = rs; s.rt = rt; s.wba = wba; s.a = a; s.b = b; s.imm = 32'h5A;
        return s;
    endfunction

    initial begin
        stim_t s;
        int    tys [8] = '{0, 1, 2, 2, 3, 5, 6, 7};
        ma = bubble(0);
        mb = bubble(0);

        // reset with a load parked on the ID inputs
        s = mk(3'd2, 5'd1, 5'd1, 5'd1, 32'hDEAD, 32'hBEEF);
        s.rst_n = 1'b0;
        drive(s); tick(); tick();
        drive(mk(3'd5, 5'd0, 5'd0, 5'd0, 0, 0)); #1;
        chk("lit_rst_type",  32'(if_a.idex_instr_type_o), 32'd5);
        chk("lit_rst_wba",   32'(if_b.idex_wba_o), 32'd0);
        chk("lit_rst_stall", 32'(if_a.stall_ifid_o), 32'd0);

        // normal RegReg capture
        drive(mk(3'd0, 5'd4, 5'd6, 5'd3, 32'h11, 32'h22)); tick();
        chk("lit_norm_rs", 32'(if_a.idex_rs_o), 32'd4);
        chk("lit_norm_rt", 32'(if_a.idex_rt_o), 32'd6);
        chk("lit_norm_a",  if_a.idex_a_o, 32'h11);
        chk("lit_norm_stall", 32'(if_a.stall_ifid_o), 32'd0);

        // load-use: one bubble then the consumer
        drive(mk(3'd2, 5'd0, 5'd0, 5'd1, 0, 0)); tick();
        drive(mk(3'd0, 5'd1, 5'd7, 5'd2, 32'h33, 32'h44)); #1;
        chk("lit_lu_stall1", 32'(if_a.stall_ifid_o), 32'd1);
        tick();
        chk("lit_lu_bubble", 32'(if_a.idex_instr_type_o), 32'd5);
        chk("lit_lu_stall2", 32'(if_a.stall_ifid_o), 32'd0);
        tick();
        chk("lit_lu_type", 32'(if_a.idex_instr_type_o), 32'd0);
        chk("lit_lu_rs",   32'(if_a.idex_rs_o), 32'd1);
        while (mb.rem > 0 || haz(mb, cur)) tick();

        // no false stall: ALUimm reading rt, then load to r0
        drive(mk(3'd2, 5'd0, 5'd0, 5'd1, 0, 0)); tick();
        drive(mk(3'd1, 5'd2, 5'd1, 5'd3, 0, 0)); #1;
        chk("lit_nofs_imm_a", 32'(if_a.stall_ifid_o), 32'd0);
        chk("lit_nofs_imm_b", 32'(if_b.stall_ifid_o), 32'd0);
        tick();
        drive(mk(3'd2, 5'd0, 5'd0, 5'd0, 0, 0)); tick();
        drive(mk(3'd0, 5'd0, 5'd0, 5'd4, 0, 0)); #1;
        chk("lit_nofs_r0", 32'(if_b.stall_ifid_o), 32'd0);
        tick();

        // flush on the second stall cycle of the 3-bubble stage
        drive(mk(3'd2, 5'd0, 5'd0, 5'd5, 0, 0)); tick();
        drive(mk(3'd0, 5'd5, 5'd0, 5'd6, 0, 0)); #1;
        chk("lit_fl_stall1", 32'(if_b.stall_ifid_o), 32'd1);
        tick();
        chk("lit_fl_stall2", 32'(if_b.stall_ifid_o), 32'd1);
        s = cur; s.flush = 1'b1; drive(s); #1;
        chk("lit_fl_forced0", 32'(if_b.stall_ifid_o), 32'd0);
        tick();
        s.flush = 1'b0; drive(s); #1;
        chk("lit_fl_bubble", 32'(if_b.idex_instr_type_o), 32'd5);
        chk("lit_fl_run",    32'(if_b.stall_ifid_o), 32'd0);
        tick();

        // hold for two cycles mid-stall
        drive(mk(3'd2, 5'd0, 5'd0, 5'd6, 0, 0)); tick();
        drive(mk(3'd0, 5'd6, 5'd0, 5'd7, 32'h66, 32'h77)); tick();
        s = cur; s.hold = 1'b1; drive(s); tick(); tick();
        chk("lit_hold_type",  32'(if_b.idex_instr_type_o), 32'd5);
        chk("lit_hold_stall", 32'(if_b.stall_ifid_o), 32'd1);
        s.hold = 1'b0; drive(s); #1;
        chk("lit_hold_s1", 32'(if_b.stall_ifid_o), 32'd1);
        tick();
        chk("lit_hold_s2", 32'(if_b.stall_ifid_o), 32'd1);
        tick();
        chk("lit_hold_s3", 32'(if_b.stall_ifid_o), 32'd0);
        tick();
        chk("lit_hold_rs", 32'(if_b.idex_rs_o), 32'd6);

        // reset mid-stall
        drive(mk(3'd2, 5'd0, 5'd0, 5'd6, 0, 0)); tick();
        drive(mk(3'd0, 5'd6, 5'd0, 5'd7, 0, 0)); tick();
        s = cur; s.rst_n = 1'b0; drive(s); tick();
        s.rst_n = 1'b1; drive(s); #1;
        chk("lit_rstm_type",  32'(if_b.idex_instr_type_o), 32'd5);
        chk("lit_rstm_stall", 32'(if_b.stall_ifid_o), 32'd0);
        tick();

        // randomized traffic on a small register space to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            s       = '0;
            s.rst_n = ($urandom_range(0, 99) != 0);
            s.hold  = ($urandom_range(0, 99) < 8);
            s.flush = ($urandom_range(0, 99) < 8);
            s.rs    = 5'($urandom_range(0, 3));
            s.rt    = 5'($urandom_range(0, 3));
            s.wba   = 5'($urandom_range(0, 3));
            s.ty    = 3'(tys[$urandom_range(0, 7)]);
            s.a     = $urandom;
            s.b     = $urandom;
            s.imm   = $urandom;
            drive(s);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
